// File: rtl/sub12u_pipe_pkg.sv
// Shared types and helpers for the pipelined 12-bit unsigned subtractor.
package sub_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int SPLIT_DEF = 6;

  // Stage-1 register contents at the default geometry.
  typedef struct packed {
    logic [SPLIT_DEF-1:0]           d_lo;
    logic                           b_lo;
    logic [WIDTH_DEF-SPLIT_DEF-1:0] a_hi;
    logic [WIDTH_DEF-SPLIT_DEF-1:0] b_hi;
  } s1_t;

  // Reference result {borrow, diff}; the extra MSB of the widened
  // subtraction is exactly the borrow out.
  function automatic logic [WIDTH_DEF:0] ref_sub(input logic [WIDTH_DEF-1:0] a,
                                                 input logic [WIDTH_DEF-1:0] b);
    logic [WIDTH_DEF:0] r;
    r = {1'b0, a} - {1'b0, b};
    return r;
  endfunction

endpackage

// File: rtl/sub12u_pipe_sub_slice.sv
// N-bit combinational ripple-borrow subtractor built from full-subtractor cells.

// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module sub_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module sub_slice #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);
  // Borrow chain: bc[i] enters bit i, bc[N] leaves the slice.
  logic [N:0] bc;

  assign bc[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    sub_fs u_fs (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bc[i]),
      .d    (d[i]),
      .bout (bc[i+1])
    );
  end

  assign bout = bc[N];
endmodule

// File: rtl/sub12u_pipe.sv
// Two-stage exact unsigned subtractor O = {borrow, A-B} with valid/ready
// handshakes and full backpressure. Low slice computed before the s1
// register, high slice (with the registered low borrow) before the output.
module sub12u_pipe
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SPLIT = SPLIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   O
);
  localparam int HI = WIDTH - SPLIT;

  // Stage-1 layout for this geometry (matches s1_t at the defaults).
  typedef struct packed {
    logic [SPLIT-1:0] d_lo;
    logic             b_lo;
    logic [HI-1:0]    a_hi;
    logic [HI-1:0]    b_hi;
  } s1_w_t;

  s1_w_t          s1;
  logic           s1_valid;
  logic [SPLIT-1:0] lo_d;
  logic           lo_b;
  logic [HI-1:0]  hi_d;
  logic           hi_b;
  logic           accept;
  logic           s2_load;
  logic           xfer;

  sub_slice #(.N(SPLIT)) u_lo (
    .a    (A[SPLIT-1:0]),
    .b    (B[SPLIT-1:0]),
    .bin  (1'b0),
    .d    (lo_d),
    .bout (lo_b)
  );

  sub_slice #(.N(HI)) u_hi (
    .a    (s1.a_hi),
    .b    (s1.b_hi),
    .bin  (s1.b_lo),
    .d    (hi_d),
    .bout (hi_b)
  );

  // Output stage moves when empty or draining; s1 refills behind it.
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // Stage 1: capture low difference/borrow and raw high operands on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1.d_lo  <= lo_d;
      s1.b_lo  <= lo_b;
      s1.a_hi  <= A[WIDTH-1:SPLIT];
      s1.b_hi  <= B[WIDTH-1:SPLIT];
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 / output: finish the high slice; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      O         <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      O         <= {hi_b, hi_d, s1.d_lo};
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub12u_pipe.sv
// Bench for sub12u_pipe: three instances (SPLIT = 6, 1, 11) share stimulus;
// a queue scoreboard per instance checks every output transfer.
module tb_sub12u_pipe;

  localparam int W  = 12;
  localparam int ND = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [W-1:0]      A = '0;
  logic [W-1:0]      B = '0;
  logic [ND-1:0]     in_ready;
  logic [ND-1:0]     out_valid;
  logic [ND-1:0][W:0] o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer [ND];
  logic [W:0] exp_q [ND][$];

  always #5 clk = ~clk;

  sub12u_pipe #(.WIDTH(W), .SPLIT(6)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .A(A), .B(B), .out_valid(out_valid[0]), .out_ready(out_ready), .O(o[0]));
  sub12u_pipe #(.WIDTH(W), .SPLIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .A(A), .B(B), .out_valid(out_valid[1]), .out_ready(out_ready), .O(o[1]));
  sub12u_pipe #(.WIDTH(W), .SPLIT(11)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .A(A), .B(B), .out_valid(out_valid[2]), .out_ready(out_ready), .O(o[2]));

  // Reference: signed integer difference; negative means borrow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = int'(a) - int'(b);
    return {(d < 0), d[W-1:0]};
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Scoreboard: negedge sees the values the next posedge will act on.
  always @(negedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (rst) begin
        exp_q[k].delete();
      end else begin
        if (out_valid[k] && out_ready) begin
          n_xfer[k]++;
          if (exp_q[k].size() == 0) begin
            chk("unexpected_result", k, int'(o[k]), -1);
          end else begin
            chk("sb_result", k, int'(o[k]), int'(exp_q[k].pop_front()));
          end
        end
        if (in_valid && in_ready[k]) exp_q[k].push_back(model(A, B));
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int x0;
    vecs[0] = '{12'd5,   12'd3,   13'h0002};
    vecs[1] = '{12'd0,   12'd1,   13'h1FFF};
    vecs[2] = '{12'hFFF, 12'hFFF, 13'h0000};
    vecs[3] = '{12'h040, 12'h001, 13'h003F};
    vecs[4] = '{12'h800, 12'h801, 13'h1FFF};
    vecs[5] = '{12'hFFF, 12'h000, 13'h0FFF};
    vecs[6] = '{12'h000, 12'hFFF, 13'h1001};
    vecs[7] = '{12'h03F, 12'h040, 13'h1FFF};
    for (int k = 0; k < ND; k++) n_xfer[k] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk("rst_out_valid", k, int'(out_valid[k]), 0);
      chk("rst_O", k, int'(o[k]), 0);
      chk("rst_in_ready", k, int'(in_ready[k]), 1);
    end

    // Directed vectors with two-cycle latency check
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; A = vecs[v].a; B = vecs[v].b; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) begin
        chk("vec_valid", k, int'(out_valid[k]), 1);
        chk("vec_O", k, int'(o[k]), int'(vecs[v].exp));
      end
    end
    @(posedge clk); #1;

    // Full throughput with out_ready held high
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; A = W'($urandom); B = W'($urandom); out_ready = 1'b1;
      @(negedge clk);
      chk("tput_in_ready", 0, int'(in_ready[0]), 1);
      if (c >= 2) chk("tput_out_valid", 0, int'(out_valid[0]), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A=100..103, B=1, out_ready low for 4 cycles
    idx = 0;
    x0 = n_xfer[0];
    for (int c = 0; c < 16; c++) begin
      in_valid = (idx < 4); A = W'(100 + idx); B = 12'd1; out_ready = (c >= 4);
      @(negedge clk);
      if (c == 2 || c == 3) begin
        chk("bp_in_ready", 0, int'(in_ready[0]), 0);
        chk("bp_hold_valid", 0, int'(out_valid[0]), 1);
        chk("bp_hold_O", 0, int'(o[0]), 99);
      end
      if (in_valid && in_ready[0]) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", 0, idx, 4);
    chk("bp_all_emerged", 0, n_xfer[0] - x0, 4);

    // Reset mid-flight discards in-flight results
    out_ready = 1'b0;
    in_valid = 1'b1; A = 12'd50; B = 12'd7;
    @(posedge clk); #1;
    A = 12'd60; B = 12'd70;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk("midrst_out_valid", k, int'(out_valid[k]), 0);
      chk("midrst_O", k, int'(o[k]), 0);
      chk("midrst_in_ready", k, int'(in_ready[k]), 1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst_no_stale", 0, int'(out_valid[0]), 0);
    end
    @(posedge clk); #1;

    // Random traffic against the scoreboard
    x0 = n_xfer[0];
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A = W'($urandom);
      B = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) chk("drain_empty", k, exp_q[k].size(), 0);
    chk("rand_activity", 0, int'(n_xfer[0] - x0 > 1000), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
